// File: rtl/pulse_measure_fifo_if.sv
// pulse_measure_fifo_if
//   Record delivery bus between the pulse measurement block and its consumer.
//   The producer presents the FIFO head record while out_valid is high, and the
//   consumer takes it by raising out_ready.
//
//   Signals:
//     out_valid  producer -> consumer  head record presented
//     out_ready  consumer -> producer  head accepted this cycle
//     out_width  producer -> consumer  high width in cycles
//     out_gap    producer -> consumer  low gap before the pulse, in cycles
//     out_flags  producer -> consumer  [0] width_err, [1] first, [2] sat
interface pulse_measure_fifo_if #(
    parameter int CNT_W = 16
);
    logic             out_valid;
    logic             out_ready;
    logic [CNT_W-1:0] out_width;
    logic [CNT_W-1:0] out_gap;
    logic [2:0]       out_flags;

    modport master (
        output out_valid,
        output out_width,
        output out_gap,
        output out_flags,
        input  out_ready
    );

    modport slave (
        input  out_valid,
        input  out_width,
        input  out_gap,
        input  out_flags,
        output out_ready
    );
endinterface

// File: rtl/pulse_measure_fifo.sv
// pulse_measure_fifo
//   Measures the high width of each completed pulse on pulse_in and the low gap
//   that preceded it, checks the width against [MIN_WIDTH, MAX_WIDTH], and
//   queues one record per pulse into a first-word-fall-through FIFO that is
//   drained over a valid/ready bus.
//
//   Ports:
//     clk          clock
//     rst          synchronous active-high reset (wins over clear)
//     pulse_in     pulse to measure, already in the clk domain
//     clear        synchronous soft clear, same effect as rst
//     overflow     sticky: a record was dropped because the FIFO was full
//     pulse_count  completed pulses since rst/clear, saturating
//     busy         a pulse is currently being measured
//     bus          record output (master side of pulse_measure_fifo_if)
module pulse_measure_fifo #(
    parameter int CNT_W     = 16,
    parameter int DEPTH     = 4,
    parameter int MIN_WIDTH = 1,
    parameter int MAX_WIDTH = 8
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    pulse_in,
    input  logic                    clear,
    output logic                    overflow,
    output logic [CNT_W-1:0]        pulse_count,
    output logic                    busy,
    pulse_measure_fifo_if.master    bus
);

    localparam int PTR_W = $clog2(DEPTH);

    typedef enum logic [1:0] {
        S_ARM  = 2'd0,
        S_IDLE = 2'd1,
        S_LOW  = 2'd2,
        S_HIGH = 2'd3
    } state_t;

    typedef struct packed {
        logic [CNT_W-1:0] width;
        logic [CNT_W-1:0] gap;
        logic [2:0]       flags;
    } rec_t;

    // ------------------------------------------------------------------
    // Measurement FSM
    // ------------------------------------------------------------------
    state_t           r_state, w_state_nxt;
    logic [CNT_W-1:0] r_width, w_width_nxt;
    logic [CNT_W-1:0] r_gap,   w_gap_nxt;
    logic             r_first, w_first_nxt;
    logic             w_push;

    logic [CNT_W-1:0] w_gap_rec;
    logic             w_sat;
    logic             w_err;
    rec_t             w_rec;

    // The first pulse after rst/clear has no preceding falling edge, so its
    // gap is reported as 0 regardless of how long the line sat low.
    assign w_gap_rec = r_first ? '0 : r_gap;
    assign w_sat     = (&r_width) | (&w_gap_rec);
    assign w_err     = (r_width < CNT_W'(MIN_WIDTH)) || (r_width > CNT_W'(MAX_WIDTH));
    assign w_rec     = '{width: r_width, gap: w_gap_rec, flags: {w_sat, r_first, w_err}};

    always_comb begin
        w_state_nxt = r_state;
        w_width_nxt = r_width;
        w_gap_nxt   = r_gap;
        w_first_nxt = r_first;
        w_push      = 1'b0;
        case (r_state)
            // Wait for the line to be low so a pulse already in progress at
            // release is never reported with a truncated width.
            S_ARM: begin
                if (!pulse_in) w_state_nxt = S_IDLE;
            end
            S_IDLE: begin
                if (pulse_in) begin
                    w_state_nxt = S_HIGH;
                    w_width_nxt = CNT_W'(1);
                    w_first_nxt = 1'b1;
                end
            end
            S_LOW: begin
                if (pulse_in) begin
                    w_state_nxt = S_HIGH;
                    w_width_nxt = CNT_W'(1);
                    w_first_nxt = 1'b0;
                end else if (!(&r_gap)) begin
                    w_gap_nxt = r_gap + CNT_W'(1);
                end
            end
            S_HIGH: begin
                // gap stays frozen here; it is the value reported on the fall
                if (pulse_in) begin
                    if (!(&r_width)) w_width_nxt = r_width + CNT_W'(1);
                end else begin
                    w_push      = 1'b1;
                    w_state_nxt = S_LOW;
                    w_gap_nxt   = CNT_W'(1);
                end
            end
            default: w_state_nxt = S_ARM;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst || clear) begin
            r_state <= S_ARM;
            r_width <= '0;
            r_gap   <= '0;
            r_first <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_width <= w_width_nxt;
            r_gap   <= w_gap_nxt;
            r_first <= w_first_nxt;
        end
    end

    assign busy = (r_state == S_HIGH);

    // ------------------------------------------------------------------
    // Record FIFO (first-word fall-through)
    // ------------------------------------------------------------------
    rec_t             r_mem [DEPTH];
    // One extra pointer bit distinguishes full from empty.
    logic [PTR_W:0]   r_wptr, r_rptr;
    logic             r_overflow;
    logic [CNT_W-1:0] r_pulse_count;

    logic             w_empty, w_full, w_pop, w_wr;
    rec_t             w_head;

    assign w_empty = (r_wptr == r_rptr);
    assign w_full  = (r_wptr[PTR_W] != r_rptr[PTR_W]) &&
                     (r_wptr[PTR_W-1:0] == r_rptr[PTR_W-1:0]);
    assign w_pop   = !w_empty && bus.out_ready;
    // A pop in the same cycle frees the slot, so a full FIFO can still accept.
    assign w_wr    = w_push && (!w_full || w_pop);

    always_ff @(posedge clk) begin
        if (rst || clear) begin
            r_wptr        <= '0;
            r_rptr        <= '0;
            r_overflow    <= 1'b0;
            r_pulse_count <= '0;
        end else begin
            if (w_wr)  r_wptr <= r_wptr + 1'b1;
            if (w_pop) r_rptr <= r_rptr + 1'b1;
            if (w_push && !w_wr) r_overflow <= 1'b1;
            // Dropped records still count as completed pulses.
            if (w_push && !(&r_pulse_count)) r_pulse_count <= r_pulse_count + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (w_wr) r_mem[r_wptr[PTR_W-1:0]] <= w_rec;
    end

    assign w_head = r_mem[r_rptr[PTR_W-1:0]];

    assign bus.out_valid = !w_empty;
    assign bus.out_width = w_empty ? '0 : w_head.width;
    assign bus.out_gap   = w_empty ? '0 : w_head.gap;
    assign bus.out_flags = w_empty ? '0 : w_head.flags;

    assign overflow    = r_overflow;
    assign pulse_count = r_pulse_count;

endmodule

// File: tb/tb_pulse_measure_fifo.sv
module tb_pulse_measure_fifo;

    logic clk;
    logic rst;
    logic clear;
    logic pulse;
    logic pulse2;

    logic        ovf,   busy;
    logic [15:0] pcnt;
    logic        ovf2,  busy2;
    logic [3:0]  pcnt2;

    int n_vec = 0;
    int n_err = 0;

    pulse_measure_fifo_if #(.CNT_W(16)) bus  ();
    pulse_measure_fifo_if #(.CNT_W(4))  bus2 ();

    pulse_measure_fifo #(.CNT_W(16), .DEPTH(4), .MIN_WIDTH(1), .MAX_WIDTH(8)) dut (
        .clk         (clk),
        .rst         (rst),
        .pulse_in    (pulse),
        .clear       (clear),
        .overflow    (ovf),
        .pulse_count (pcnt),
        .busy        (busy),
        .bus         (bus)
    );

    // Narrow-counter instance for saturation checks
    pulse_measure_fifo #(.CNT_W(4), .DEPTH(4), .MIN_WIDTH(1), .MAX_WIDTH(8)) dut4 (
        .clk         (clk),
        .rst         (rst),
        .pulse_in    (pulse2),
        .clear       (1'b0),
        .overflow    (ovf2),
        .pulse_count (pcnt2),
        .busy        (busy2),
        .bus         (bus2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic cyc(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    initial begin
        rst   = 1'b1;
        clear = 1'b0;
        pulse = 1'b1;
        pulse2 = 1'b0;
        bus.out_ready  = 1'b0;
        bus2.out_ready = 1'b1;
        cyc(2);

        // reset state
        chk("rst_valid", 32'(bus.out_valid), 0);
        chk("rst_width", 32'(bus.out_width), 0);
        chk("rst_gap",   32'(bus.out_gap),   0);
        chk("rst_flags", 32'(bus.out_flags), 0);
        chk("rst_ovf",   32'(ovf),  0);
        chk("rst_pcnt",  32'(pcnt), 0);
        chk("rst_busy",  32'(busy), 0);

        // pulse already high at release is never measured
        rst = 1'b0;
        repeat (3) begin
            cyc(1);
            chk("arm_hi_busy",  32'(busy), 0);
            chk("arm_hi_valid", 32'(bus.out_valid), 0);
        end
        pulse = 1'b0;
        repeat (4) begin
            cyc(1);
            chk("arm_lo_valid", 32'(bus.out_valid), 0);
            chk("arm_lo_pcnt",  32'(pcnt), 0);
            chk("arm_lo_busy",  32'(busy), 0);
        end

        // high 2, low 5, high 2, low
        bus.out_ready = 1'b1;
        pulse = 1'b1; cyc(1);
        chk("p1_busy", 32'(busy), 1);
        cyc(1);
        pulse = 1'b0; cyc(1);
        chk("p1_valid", 32'(bus.out_valid), 1);
        chk("p1_width", 32'(bus.out_width), 2);
        chk("p1_gap",   32'(bus.out_gap),   0);
        chk("p1_flags", 32'(bus.out_flags), 32'b010);
        chk("p1_busy0", 32'(busy), 0);
        cyc(4);
        chk("p1_popped", 32'(bus.out_valid), 0);
        pulse = 1'b1; cyc(2);
        chk("p2_pre_valid", 32'(bus.out_valid), 0);
        pulse = 1'b0; cyc(1);
        chk("p2_valid", 32'(bus.out_valid), 1);
        chk("p2_width", 32'(bus.out_width), 2);
        chk("p2_gap",   32'(bus.out_gap),   5);
        chk("p2_flags", 32'(bus.out_flags), 32'b000);
        chk("p2_pcnt",  32'(pcnt), 2);

        // 10-wide pulse exceeds MAX_WIDTH
        pulse = 1'b1; cyc(10);
        pulse = 1'b0; cyc(1);
        chk("wide_width", 32'(bus.out_width), 10);
        chk("wide_gap",   32'(bus.out_gap),   1);
        chk("wide_flags", 32'(bus.out_flags), 32'b001);
        chk("wide_pcnt",  32'(pcnt), 3);
        cyc(1);

        // CNT_W=4: 20-wide pulse saturates at 15
        pulse2 = 1'b1; cyc(20);
        pulse2 = 1'b0; cyc(1);
        chk("sat_valid", 32'(bus2.out_valid), 1);
        chk("sat_width", 32'(bus2.out_width), 15);
        chk("sat_gap",   32'(bus2.out_gap),   0);
        chk("sat_flags", 32'(bus2.out_flags), 32'b111);

        // overflow: 5 pulses into a 4-deep FIFO with no consumer
        bus.out_ready = 1'b0;
        clear = 1'b1; cyc(1);
        clear = 1'b0;
        chk("clr_pcnt",  32'(pcnt), 0);
        chk("clr_valid", 32'(bus.out_valid), 0);
        chk("clr_ovf",   32'(ovf), 0);
        cyc(1);
        repeat (5) begin
            pulse = 1'b1; cyc(1);
            pulse = 1'b0; cyc(3);
        end
        chk("ovf_valid", 32'(bus.out_valid), 1);
        chk("ovf_flag",  32'(ovf), 1);
        chk("ovf_pcnt",  32'(pcnt), 5);
        bus.out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            chk("ovf_rd_valid", 32'(bus.out_valid), 1);
            chk("ovf_rd_width", 32'(bus.out_width), 1);
            chk("ovf_rd_gap",   32'(bus.out_gap), (i == 0) ? 0 : 3);
            chk("ovf_rd_flags", 32'(bus.out_flags), (i == 0) ? 32'b010 : 32'b000);
            cyc(1);
        end
        chk("ovf_drained", 32'(bus.out_valid), 0);
        chk("ovf_sticky",  32'(ovf), 1);

        // full FIFO with push and pop in the same cycle
        bus.out_ready = 1'b0;
        clear = 1'b1; cyc(1);
        clear = 1'b0; cyc(1);
        repeat (4) begin
            pulse = 1'b1; cyc(1);
            pulse = 1'b0; cyc(3);
        end
        chk("full_valid", 32'(bus.out_valid), 1);
        chk("full_ovf0",  32'(ovf), 0);
        pulse = 1'b1; cyc(2);
        pulse = 1'b0;
        bus.out_ready = 1'b1;
        cyc(1);
        bus.out_ready = 1'b0;
        chk("pp_ovf",  32'(ovf), 0);
        chk("pp_pcnt", 32'(pcnt), 5);
        chk("pp_head_gap", 32'(bus.out_gap), 3);
        bus.out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            chk("pp_rd_valid", 32'(bus.out_valid), 1);
            chk("pp_rd_width", 32'(bus.out_width), (i == 3) ? 2 : 1);
            chk("pp_rd_gap",   32'(bus.out_gap), 3);
            cyc(1);
        end
        chk("pp_drained", 32'(bus.out_valid), 0);

        // clear in the 2nd high cycle of a 4-cycle pulse
        pulse = 1'b1; cyc(1);
        chk("mid_busy1", 32'(busy), 1);
        clear = 1'b1; cyc(1);
        clear = 1'b0;
        chk("mid_busy0", 32'(busy), 0);
        chk("mid_pcnt",  32'(pcnt), 0);
        chk("mid_valid", 32'(bus.out_valid), 0);
        cyc(2);
        chk("mid_arm_busy", 32'(busy), 0);
        pulse = 1'b0; cyc(1);
        chk("mid_no_rec",  32'(bus.out_valid), 0);
        chk("mid_pcnt2",   32'(pcnt), 0);
        pulse = 1'b1; cyc(3);
        pulse = 1'b0; cyc(1);
        chk("post_valid", 32'(bus.out_valid), 1);
        chk("post_width", 32'(bus.out_width), 3);
        chk("post_gap",   32'(bus.out_gap),   0);
        chk("post_flags", 32'(bus.out_flags), 32'b010);
        chk("post_pcnt",  32'(pcnt), 1);
        cyc(2);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/pulse_measure_fifo.md
Name: pulse_measure_fifo

Overview:
- Downstream consumer of the one-shot pulse generator's `pulse` output.
- Measures each completed pulse's high width and the low gap before it, in clk cycles.
- Checks the width against configured limits and queues one record per pulse into a small first-word-fall-through FIFO.
- A valid/ready interface delivers the records to a host or logger stage.

Parameters:
- CNT_W, 16: width of the width, gap and pulse-count counters.
- DEPTH, 4: FIFO entries; power of 2, >= 2.
- MIN_WIDTH, 1: minimum legal pulse width in cycles.
- MAX_WIDTH, 8: maximum legal pulse width in cycles.

Ports:
- clk  in  1  clock.
- rst  in  1  reset; synchronous, active-high.
- pulse_in  in  1  pulse to measure; same clock domain, no synchronizer.
- clear  in  1  synchronous soft clear.
- out_valid  out  1  FIFO non-empty; head record presented.
- out_ready  in  1  consumer accepts head when out_valid=1.
- out_width  out  CNT_W  head record: high cycles.
- out_gap  out  CNT_W  head record: low cycles since previous pulse fell.
- out_flags  out  3  head record: [0] width_err, [1] first, [2] sat.
- overflow  out  1  sticky: a record was dropped.
- pulse_count  out  CNT_W  completed pulses since rst/clear; saturating.
- busy  out  1  high while a pulse is being measured (state HIGH).

Behaviour:
- Reset and clear:
  - rst has priority over clear; clear has priority over all other activity.
  - Either one sets: FIFO empty, state ARM, all counters 0, overflow 0, pulse_count 0.
  - Outputs after rst/clear: out_valid 0, out_width/out_gap/out_flags 0, overflow 0, pulse_count 0, busy 0.
- Data gating: out_width, out_gap and out_flags read 0 whenever out_valid=0.
- FSM, evaluated at each clk edge on sampled pulse_in:
  - ARM: pulse_in=0 -> IDLE. A pulse already high at rst/clear release is never measured.
  - IDLE: pulse_in=1 -> HIGH, width<=1, first<=1.
  - LOW: pulse_in=1 -> HIGH, width<=1, first<=0. pulse_in=0 -> gap<=gap+1, saturating.
  - HIGH: pulse_in=1 -> width<=width+1, saturating. pulse_in=0 -> push record, state LOW, gap<=1.
- Gap value in the record:
  - first=1: gap field = 0.
  - Otherwise: the gap count as it stood when the pulse rose.
  - gap is frozen while in HIGH.
- Flags:
  - sat=1 if width or gap reached all-ones.
  - width_err=1 if width<MIN_WIDTH or width>MAX_WIDTH, using the saturated width value.
- Latency: the push occurs at the edge where pulse_in is first sampled low. If the FIFO was empty, out_valid=1 in the cycle after that edge, with the record on the out_* lines.
- pulse_count increments on every push event, including dropped ones; it saturates at all-ones.
- FIFO:
  - Pop when out_valid & out_ready.
  - Push while full with no pop: record dropped, overflow<=1 (sticky until rst/clear), FIFO contents unchanged.
  - Push and pop in the same cycle while full: both occur, no overflow.
  - Push and pop in the same cycle while at count 1: out_valid stays 1, and the new record is presented next cycle.
  - Pointers wrap modulo DEPTH; records are delivered strictly in order.
  - out_ready while out_valid=0 has no effect.
- Clear mid-pulse: the partial pulse is discarded, no record is pushed, and the FSM returns to ARM.

Test Plan:
- rst released with pulse_in=1 held 3 cycles, then 0 for 4 cycles -> no record, out_valid=0, pulse_count=0, busy=0 throughout.
- out_ready=1; pulse high 2 cycles, low 5, high 2, then low -> records {width 2, gap 0, flags 3'b010} then {width 2, gap 5, flags 3'b000}; each record's out_valid rises 1 cycle after its falling-edge sample; pulse_count=2.
- Pulse 10 cycles wide (MAX_WIDTH=8) -> width 10, flags[0]=1. CNT_W=4, pulse 20 cycles wide -> width 15, flags[2]=1, flags[0]=1.
- out_ready=0; 5 pulses of width 1, gap 3 -> out_valid=1, overflow=1, pulse_count=5. Then out_ready=1 -> exactly 4 records, gaps 0,3,3,3 in order, then out_valid=0.
- FIFO full, out_ready=1 in the cycle a push occurs -> head popped and new record stored, overflow stays 0, count stays 4.
- clear asserted in the 2nd high cycle of a 4-cycle pulse -> no record, busy=0 next cycle, pulse_count=0. The next full pulse gives flags[1]=1 and gap 0.
